// File: rtl/spi_24b_txq_if.sv
// Purpose : bundles the write-side and spi_24b-side signals of the TX queue.
// Latency : n/a (signal bundle only).
// Backpres: write side sees full/overflow; serialiser side is spi_en/spi_done level handshake.
// Ports   : wr_en, wr_data, full, empty, count, overflow, busy (control side);
//           spi_en, spi_data_out, spi_done (serialiser side); timeout_err (status).
//           master = control logic + serialiser environment, slave = the queue itself.
interface spi_24b_txq_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [23:0]   wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          busy;
  logic          spi_en;
  logic [23:0]   spi_data_out;
  logic          spi_done;
  logic          timeout_err;

  modport master (
    output wr_en, wr_data, spi_done,
    input  full, empty, count, overflow, busy, spi_en, spi_data_out, timeout_err
  );

  modport slave (
    input  wr_en, wr_data, spi_done,
    output full, empty, count, overflow, busy, spi_en, spi_data_out, timeout_err
  );
endinterface

// File: rtl/spi_24b_txq.sv
// Purpose : 24-bit word queue + sequencer driving the spi_24b serialiser with an idle gap between words.
// Latency : write sampled at edge N -> spi_en=1 after edge N+1 (queue empty, FSM idle).
// Backpres: writes refused while full (sticky overflow); words held until spi_done.
// Ports   : clk, rst (sync, active-high); bus (spi_24b_txq_if.slave) carries the
//           write port, queue status, busy, spi_en/spi_data_out/spi_done and timeout_err.
// Config  : define SPI_TXQ_TIMEOUT_EN to enable the SEND watchdog (TIMEOUT_CYCLES);
//           otherwise timeout_err is tied 0 and SEND waits for spi_done indefinitely.
module spi_24b_txq #(
  parameter int DEPTH          = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          rst,
  spi_24b_txq_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Gap counter needs at least one bit even when GAP_CYCLES is 0 or 1.
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t        state;
  logic [23:0]   mem [DEPTH];
  logic [AW:0]   wr_ptr;   // MSB is the wrap bit
  logic [AW:0]   rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic          full_q;
  logic          empty_q;
  logic          overflow_q;
  logic          spi_en_q;
  logic [23:0]   data_q;
  logic [GW-1:0] gap_cnt;
  logic          push;
  logic          pop;
  logic          abort;

  // Refusal uses the registered full flag, so a same-cycle pop never frees a slot early.
  assign push = bus.wr_en && !full_q;
  assign pop  = (state == IDLE) && !empty_q;

  always_comb begin
    count_nxt = count_q;
    case ({push, pop})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.wr_data;
  end

`ifdef SPI_TXQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
  logic          timeout_q;

  // wd_cnt is 0 on the first SEND cycle, so the abort edge is TIMEOUT_CYCLES after spi_en rose.
  assign abort = (state == SEND) && !bus.spi_done && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt <= (state == SEND) ? wd_cnt + TW'(1) : '0;
      if (abort) timeout_q <= 1'b1;
    end
  end

  assign bus.timeout_err = timeout_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign abort           = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      spi_en_q   <= 1'b0;
      data_q     <= '0;
      gap_cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_nxt;
      full_q  <= (count_nxt == CW'(DEPTH));
      empty_q <= (count_nxt == '0);
      if (bus.wr_en && full_q) overflow_q <= 1'b1;

      case (state)
        IDLE: begin
          if (!empty_q) begin
            data_q   <= mem[rd_ptr[AW-1:0]];
            spi_en_q <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          // A watchdog abort leaves the same way as a completed word; the word is simply dropped.
          if (bus.spi_done || abort) begin
            spi_en_q <= 1'b0;
            gap_cnt  <= '0;
            state    <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= IDLE;
          else                                gap_cnt <= gap_cnt + GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.spi_en       = spi_en_q;
  assign bus.spi_data_out = data_q;
  assign bus.busy         = (state != IDLE) || !empty_q;
endmodule
